// File: rtl/intc_arbiter.sv
// intc_arbiter: fixed-priority platform interrupt controller.
// Lowest source index wins. The controller latches pending interrupts,
// presents one ID at a time to the core, masks the source while it is in
// service, and returns to arbitration when software writes the matching ID
// to CLAIM.
// Optional feature: define INTC_EDGE_TRIG_EN for rising-edge sources.
// Leave it undefined (the default) for level-sensitive sources.
module intc_arbiter #(
  parameter int NUM_SRC        = 8,
  parameter int INT_CODE_WIDTH = 4,
  parameter int MAX_BIT_POS    = 31
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        irq_src,
  output logic [INT_CODE_WIDTH-1:0] peripheral_int_code,
  input  logic                      int_ack,
  input  logic [3:0]                reg_addr,
  input  logic [MAX_BIT_POS:0]      reg_wdata,
  input  logic                      reg_we,
  input  logic                      reg_re,
  output logic [MAX_BIT_POS:0]      reg_rdata,
  output logic                      reg_rvalid
);

  localparam int DW = MAX_BIT_POS + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_e;

  state_e                    state_q;
  logic [NUM_SRC-1:0]        pending_q, pending_d, enable_q;
  logic [INT_CODE_WIDTH-1:0] cur_id_q, code_q, sel_id;
  logic [NUM_SRC-1:0]        cur_oh, set_ev, clr_vec, req_vec;
  logic [DW-1:0]             rdata_q, rdata_d;
  logic                      rvalid_q;
  logic                      claim, complete, cur_en;

  assign req_vec = pending_q & enable_q;
  assign cur_en  = |(cur_oh & enable_q);

  // A claim is an ack pulse or a CLAIM read while a request is outstanding.
  // Both in the same cycle still count as a single claim.
  assign claim    = (state_q == S_REQ) &&
                    (int_ack || (reg_re && reg_addr == 4'h8));
  assign complete = (state_q == S_SERVICE) && reg_we && reg_addr == 4'h8 &&
                    (reg_wdata == DW'(cur_id_q));
  assign clr_vec  = claim ? cur_oh : '0;

  // Decode cur_id into a one-hot mask. ID 0 gives an all-zero mask.
  always_comb begin
    cur_oh = '0;
    for (int i = 0; i < NUM_SRC; i++)
      cur_oh[i] = (cur_id_q == INT_CODE_WIDTH'(i + 1));
  end

  // Fixed-priority select. The lowest index takes the last assignment.
  always_comb begin
    sel_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (req_vec[i]) sel_id = INT_CODE_WIDTH'(i + 1);
  end

`ifdef INTC_EDGE_TRIG_EN
  logic [NUM_SRC-1:0] irq_prev_q;

  // Track the previous line value so rising edges can be detected.
  always_ff @(posedge clk) begin
    if (rst) irq_prev_q <= '0;
    else     irq_prev_q <= irq_src;
  end

  assign set_ev = irq_src & ~irq_prev_q;

  // Edge events are latched even during service. When an edge coincides
  // with a claim, the edge wins so the source re-pends.
  always_comb pending_d = (pending_q & ~clr_vec) | set_ev;
`else
  logic [NUM_SRC-1:0] svc_mask;

  assign set_ev = irq_src;

  // The in-service source cannot re-pend. The mask lifts in the completion
  // cycle, so a line held high requests again two cycles after completion.
  assign svc_mask = (state_q == S_SERVICE && !complete) ? cur_oh : '0;

  // In level mode a claim clears pending even if the line is still high.
  always_comb pending_d = (pending_q | (set_ev & ~svc_mask)) & ~clr_vec;
`endif

  // Pending latch and software-writable enable mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      enable_q  <= '0;
    end else begin
      pending_q <= pending_d;
      if (reg_we && reg_addr == 4'h4) enable_q <= reg_wdata[NUM_SRC-1:0];
    end
  end

  // Request FSM. The interrupt code is registered together with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cur_id_q <= '0;
      code_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (|req_vec) begin
          state_q  <= S_REQ;
          cur_id_q <= sel_id;
          code_q   <= sel_id;
        end
        S_REQ: if (claim) begin
          state_q <= S_SERVICE;
          code_q  <= '0;
        end else if (!cur_en) begin
          // Withdraw the request; the pending bit is kept.
          state_q  <= S_IDLE;
          cur_id_q <= '0;
          code_q   <= '0;
        end
        S_SERVICE: if (complete) begin
          state_q  <= S_IDLE;
          cur_id_q <= '0;
        end
        default: begin
          state_q  <= S_IDLE;
          cur_id_q <= '0;
          code_q   <= '0;
        end
      endcase
    end
  end

  // Read mux. Data is taken from pre-write state, so a read and a write in
  // the same cycle return the old value.
  always_comb begin
    rdata_d = '0;
    case (reg_addr)
      4'h0: rdata_d[NUM_SRC-1:0] = pending_q;
      4'h4: rdata_d[NUM_SRC-1:0] = enable_q;
      4'h8: rdata_d[INT_CODE_WIDTH-1:0] = (state_q == S_IDLE) ? '0 : cur_id_q;
      4'hC: begin
        rdata_d[9:8]                = state_q;
        rdata_d[INT_CODE_WIDTH-1:0] = cur_id_q;
      end
      default: rdata_d = '0;
    endcase
  end

  // Register read data with a one-cycle valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= reg_re ? rdata_d : '0;
      rvalid_q <= reg_re;
    end
  end

  assign peripheral_int_code = code_q;
  assign reg_rdata           = rdata_q;
  assign reg_rvalid          = rvalid_q;

endmodule

// File: tb/tb_intc_arbiter.sv
// Directed bench for intc_arbiter. Inputs change 1ns after each rising edge
// and outputs are sampled at that same point.
module tb_intc_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_src;
  logic [3:0]  peripheral_int_code;
  logic        int_ack;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [31:0] reg_rdata;
  logic        reg_rvalid;

  int checks   = 0;
  int failures = 0;

  localparam logic [3:0] A_PEND = 4'h0, A_EN = 4'h4, A_CLAIM = 4'h8, A_STAT = 4'hC;

  intc_arbiter #(.NUM_SRC(8), .INT_CODE_WIDTH(4), .MAX_BIT_POS(31)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src),
    .peripheral_int_code(peripheral_int_code), .int_ack(int_ack),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_re(reg_re), .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    reg_addr = a; reg_wdata = d; reg_we = 1'b1;
    tick();
    reg_we = 1'b0;
  endtask

  // A read issued in one cycle must show rvalid and data in the next cycle.
  task automatic rd_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    reg_addr = a; reg_re = 1'b1;
    tick();
    reg_re = 1'b0;
    check({tag, "_rvalid"}, {31'd0, reg_rvalid}, 32'd1);
    check(tag, reg_rdata, exp);
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic code_is(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, peripheral_int_code}, {28'd0, exp});
  endtask

  initial begin
    rst = 1'b1; irq_src = '0; int_ack = 1'b0;
    reg_addr = '0; reg_wdata = '0; reg_we = 1'b0; reg_re = 1'b0;
    tick(); tick();
    check("rst_code",   {28'd0, peripheral_int_code}, 32'd0);
    check("rst_rvalid", {31'd0, reg_rvalid}, 32'd0);
    check("rst_rdata",  reg_rdata, 32'd0);
    rst = 1'b0;
    rd_check("rst_pend", A_PEND, 32'h0);
    rd_check("rst_en",   A_EN,   32'h0);
    rd_check("rst_stat", A_STAT, 32'h0);

    // A pulse on source 2 gives code 3 two cycles later.
    wr(A_EN, 32'hFF);
    rd_check("en_ff", A_EN, 32'hFF);
    irq_src = 8'h04; tick(); irq_src = 8'h00;
    code_is("s2_n1", 4'd0);
    tick();
    code_is("s2_n2", 4'd3);
    ack();
    code_is("s2_ack", 4'd0);
    rd_check("s2_svc_stat", A_STAT, 32'h203);
    wr(A_CLAIM, 32'd3);
    rd_check("s2_done_stat", A_STAT, 32'h0);

    // Sources 5 and 1 arrive together; the lower index wins.
    irq_src = 8'h22; tick(); irq_src = 8'h00; tick();
    code_is("pri_first", 4'd2);
    ack();
    wr(A_CLAIM, 32'd2);
    code_is("pri_c1", 4'd0);
    tick();
    code_is("pri_c2", 4'd6);
    rd_check("pri_claimrd", A_CLAIM, 32'd6);
    code_is("pri_rdclaim", 4'd0);
    wr(A_CLAIM, 32'd6);

    // A disabled source is still latched as pending.
    wr(A_EN, 32'hEF);
    irq_src = 8'h10; tick(); tick(); tick();
    code_is("dis_code", 4'd0);
    rd_check("dis_pend", A_PEND, 32'h10);
    wr(A_EN, 32'hFF);
    tick();
    code_is("en_code", 4'd5);
    irq_src = 8'h00;

    // Clearing the enable during REQ withdraws the request.
    wr(A_EN, 32'hEF);
    tick();
    code_is("wd_code", 4'd0);
    rd_check("wd_stat", A_STAT, 32'h0);
    rd_check("wd_pend", A_PEND, 32'h10);
    wr(A_EN, 32'hFF);
    tick();
    code_is("wd_reen", 4'd5);
    ack();
    wr(A_CLAIM, 32'd5);

    // A combined ack and CLAIM read counts as one claim.
    // A wrong completion ID is then ignored.
    irq_src = 8'h04; tick(); irq_src = 8'h00; tick();
    code_is("svc_req", 4'd3);
    int_ack = 1'b1; reg_addr = A_CLAIM; reg_re = 1'b1;
    tick();
    int_ack = 1'b0; reg_re = 1'b0;
    check("dual_claim_rd", reg_rdata, 32'd3);
    code_is("dual_claim_code", 4'd0);
    rd_check("dual_stat", A_STAT, 32'h203);
    wr(A_CLAIM, 32'd7);
    check("bad_cpl_rvalid", {31'd0, reg_rvalid}, 32'd0);
    rd_check("bad_cpl_stat", A_STAT, 32'h203);
    rd_check("svc_claimrd", A_CLAIM, 32'd3);
    tick();
    check("rvalid_pulse", {31'd0, reg_rvalid}, 32'd0);
    wr(A_CLAIM, 32'd3);
    rd_check("svc_done", A_STAT, 32'h0);

`ifdef INTC_EDGE_TRIG_EN
    // A second edge during service re-requests after completion.
    irq_src = 8'h01; tick(); irq_src = 8'h00; tick();
    code_is("rep_req", 4'd1);
    ack();
    irq_src = 8'h01; tick(); irq_src = 8'h00;
    rd_check("rep_pend", A_PEND, 32'h1);
    wr(A_CLAIM, 32'd1);
    code_is("rep_c1", 4'd0);
    tick();
    code_is("rep_c2", 4'd1);
    ack();
    wr(A_CLAIM, 32'd1);
`else
    // A level held high does not re-pend in service.
    // It requests again two cycles after completion.
    irq_src = 8'h01; tick(); tick();
    code_is("rep_req", 4'd1);
    ack();
    rd_check("rep_pend", A_PEND, 32'h0);
    wr(A_CLAIM, 32'd1);
    code_is("rep_c1", 4'd0);
    tick();
    code_is("rep_c2", 4'd1);
    irq_src = 8'h00;
    ack();
    wr(A_CLAIM, 32'd1);
`endif

    // A read and a write in the same cycle return the pre-write value.
    // Unmapped and read-only writes are ignored.
    reg_addr = A_EN; reg_wdata = 32'h0F; reg_we = 1'b1; reg_re = 1'b1;
    tick();
    reg_we = 1'b0; reg_re = 1'b0;
    check("rw_old", reg_rdata, 32'hFF);
    rd_check("rw_new", A_EN, 32'h0F);
    wr(4'h3, 32'hFFFF_FFFF);
    rd_check("unmapped", 4'h3, 32'h0);
    wr(A_PEND, 32'hFF);
    rd_check("pend_ro", A_PEND, 32'h0);

    // Reset during SERVICE aborts the interrupt without a completion.
    wr(A_EN, 32'hFF);
    irq_src = 8'h08; tick(); irq_src = 8'h00; tick();
    code_is("mid_req", 4'd4);
    ack();
    rst = 1'b1; tick(); rst = 1'b0;
    code_is("mid_rst_code", 4'd0);
    rd_check("mid_rst_stat", A_STAT, 32'h0);
    rd_check("mid_rst_en",   A_EN,   32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
